mmio_bridge_ng: RTL and testbench

//  Next-generation CPU-to-peripheral bridge: parametrised N-channel MMIO decoder with a req/ack handshake,
//  per-access wait states and a bus-timeout watchdog, so slow or multi-cycle peripherals can hang off the bus.

---
 rtl/mmio_bridge_ng_pkg.sv | 35 +++
 rtl/mmio_bridge_ng_addr_decode.sv | 42 ++++
 rtl/mmio_bridge_ng.sv | 202 ++++++++++++++++++++
 tb/tb_mmio_bridge_ng.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_ng_pkg.sv
// -----------------------------------------------------------------------------
// mmio_bridge_ng_pkg
//   Shared definitions for the MMIO bridge: FSM state encoding, the default
//   MMIO page, the default peripheral address map and the error read value.
//   Default channel map (channel 0 is the DRAM fall-through target):
//     ch1 LED, ch2 SW, ch3 BTN, ch4 7-seg, ch5 timer, ch6/ch7 spare.
// -----------------------------------------------------------------------------
package mmio_bridge_ng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned N_PERI_DEFAULT    = 8;
  localparam logic [19:0] PERI_PAGE_DEFAULT = 20'hFFFFF;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_FFFF;

  localparam logic [31:0] PERI_ADDR_LED    = 32'hFFFF_F060;
  localparam logic [31:0] PERI_ADDR_SW     = 32'hFFFF_F070;
  localparam logic [31:0] PERI_ADDR_BTN    = 32'hFFFF_F078;
  localparam logic [31:0] PERI_ADDR_SEG    = 32'hFFFF_F000;
  localparam logic [31:0] PERI_ADDR_TIMER  = 32'hFFFF_F020;
  localparam logic [31:0] PERI_ADDR_SPARE0 = 32'hFFFF_F030;
  localparam logic [31:0] PERI_ADDR_SPARE1 = 32'hFFFF_F040;

  // Flat map, channel i in bits [32*i +: 32]; entry 0 is never compared.
  // Only valid for the default 8-channel configuration.
  localparam logic [N_PERI_DEFAULT*32-1:0] PERI_ADDRS_DEFAULT = {
    PERI_ADDR_SPARE1, PERI_ADDR_SPARE0, PERI_ADDR_TIMER, PERI_ADDR_SEG,
    PERI_ADDR_BTN,    PERI_ADDR_SW,     PERI_ADDR_LED,   32'h0000_0000
  };

endpackage

// File: rtl/mmio_bridge_ng_addr_decode.sv
// -----------------------------------------------------------------------------
// mmio_addr_decode
//   Combinational address decoder for the MMIO bridge.
//   Ports:
//     addr_i  in  32      byte address to decode
//     sel_o   out N_PERI  one-hot channel select (all zero on a miss)
//     miss_o  out 1       address is in the MMIO page but matches no channel
//   Anything outside the MMIO page goes to channel 0 (DRAM). Inside the page
//   only exact address matches hit; if the map has duplicates the lowest
//   channel index wins.
// -----------------------------------------------------------------------------
module mmio_addr_decode
  import mmio_bridge_ng_pkg::*;
#(
  parameter int unsigned              N_PERI     = N_PERI_DEFAULT,
  parameter logic [19:0]              PERI_PAGE  = PERI_PAGE_DEFAULT,
  parameter logic [N_PERI*32-1:0]     PERI_ADDRS = PERI_ADDRS_DEFAULT
) (
  input  logic [31:0]       addr_i,
  output logic [N_PERI-1:0] sel_o,
  output logic              miss_o
);

  // NOTE: every signal written in always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_o = '0;
    if (addr_i[31:12] != PERI_PAGE) begin
      sel_o[0] = 1'b1;
    end else begin
      // Scan downwards so the lowest matching index is the last one written.
      for (int i = int'(N_PERI) - 1; i >= 1; i--) begin
        if (addr_i == PERI_ADDRS[32*i +: 32]) begin
          sel_o    = '0;
          sel_o[i] = 1'b1;
        end
      end
    end
    miss_o = ~|sel_o;
  end

endmodule

// File: rtl/mmio_bridge_ng.sv
// -----------------------------------------------------------------------------
// mmio_bridge_ng
//   CPU-to-peripheral bridge with an N-channel MMIO decoder, req/ack handshake
//   to the peripherals, arbitrary wait states and a bus-timeout watchdog.
//   Ports:
//     clk_from_cpu    in   1          clock
//     rst_from_cpu    in   1          synchronous reset, active-low
//     req_from_cpu    in   1          access request, held until accepted
//     we_from_cpu     in   1          1 = write, 0 = read
//     addr_from_cpu   in   32         byte address
//     wdata_from_cpu  in   32         write data
//     ready_to_cpu    out  1          bridge idle, request can be accepted
//     ack_to_cpu      out  1          one-cycle completion pulse
//     rdata_to_cpu    out  32         read data, valid with ack_to_cpu
//     err_to_cpu      out  1          decode miss / timeout, valid with ack
//     err_count       out  16         saturating failed-access count
//     peri_req        out  N_PERI     one-hot, one-cycle request strobe
//     peri_we         out  1          registered write enable
//     peri_addr       out  32         registered address
//     peri_wdata      out  32         registered write data
//     peri_rdata      in   N_PERI*32  channel i read data in [32*i +: 32]
//     peri_ack        in   N_PERI     channel completion, only looked at in
//                                     WAIT for the selected channel
//   Flow: IDLE -(accept)-> WAIT -(ack | timeout)-> RESP -> IDLE, and a decode
//   miss goes IDLE -> RESP directly.
// -----------------------------------------------------------------------------
module mmio_bridge_ng
  import mmio_bridge_ng_pkg::*;
#(
  parameter int unsigned          N_PERI     = N_PERI_DEFAULT,
  parameter logic [19:0]          PERI_PAGE  = PERI_PAGE_DEFAULT,
  parameter logic [N_PERI*32-1:0] PERI_ADDRS = PERI_ADDRS_DEFAULT,
  parameter int unsigned          TIMEOUT    = 16,
  parameter logic [31:0]          ERR_RDATA  = ERR_RDATA_DEFAULT
) (
  input  logic                   clk_from_cpu,
  input  logic                   rst_from_cpu,
  input  logic                   req_from_cpu,
  input  logic                   we_from_cpu,
  input  logic [31:0]            addr_from_cpu,
  input  logic [31:0]            wdata_from_cpu,
  output logic                   ready_to_cpu,
  output logic                   ack_to_cpu,
  output logic [31:0]            rdata_to_cpu,
  output logic                   err_to_cpu,
  output logic [15:0]            err_count,
  output logic [N_PERI-1:0]      peri_req,
  output logic                   peri_we,
  output logic [31:0]            peri_addr,
  output logic [31:0]            peri_wdata,
  input  logic [N_PERI*32-1:0]   peri_rdata,
  input  logic [N_PERI-1:0]      peri_ack
);

  // The counter holds 0..TIMEOUT-1; reaching TIMEOUT-1 in WAIT without an ack
  // means this is the TIMEOUT-th wait cycle and the access is aborted.
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [N_PERI-1:0]   sel_q, sel_d;
  logic [N_PERI-1:0]   peri_req_q, peri_req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [15:0]         err_count_q, err_count_d;

  logic [N_PERI-1:0]   dec_sel;
  logic                dec_miss;
  logic [31:0]         sel_rdata;
  logic                sel_ack;
  logic                err_event;

  mmio_addr_decode #(
    .N_PERI     (N_PERI),
    .PERI_PAGE  (PERI_PAGE),
    .PERI_ADDRS (PERI_ADDRS)
  ) u_decode (
    .addr_i (addr_from_cpu),
    .sel_o  (dec_sel),
    .miss_o (dec_miss)
  );

  // Read data of the channel latched at accept time (sel_q is one-hot).
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < int'(N_PERI); i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | peri_rdata[32*i +: 32];
    end
  end

  // Acks from channels other than the selected one never reach the FSM.
  assign sel_ack = |(peri_ack & sel_q);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    peri_req_d  = '0;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    err_event   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_from_cpu) begin
          we_d    = we_from_cpu;
          addr_d  = addr_from_cpu;
          wdata_d = wdata_from_cpu;
          sel_d   = dec_sel;
          cnt_d   = '0;
          if (dec_miss) begin
            state_d   = ST_RESP;
            err_d     = 1'b1;
            rdata_d   = ERR_RDATA;
            err_event = 1'b1;
          end else begin
            state_d    = ST_WAIT;
            peri_req_d = dec_sel;
            err_d      = 1'b0;
          end
        end
      end

      ST_WAIT: begin
        // An ack on the expiry cycle still completes the access normally.
        if (sel_ack) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : sel_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_RESP;
          err_d     = 1'b1;
          rdata_d   = ERR_RDATA;
          err_event = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Counted when the failed access is committed, so the new count is
    // already visible during its ack cycle.
    if (err_event && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_from_cpu) begin
    if (!rst_from_cpu) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      peri_req_q  <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      peri_req_q  <= peri_req_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign ready_to_cpu = (state_q == ST_IDLE);
  assign ack_to_cpu   = (state_q == ST_RESP);
  assign err_to_cpu   = err_q & ack_to_cpu;
  assign rdata_to_cpu = rdata_q;
  assign err_count    = err_count_q;
  assign peri_req     = peri_req_q;
  assign peri_we      = we_q;
  assign peri_addr    = addr_q;
  assign peri_wdata   = wdata_q;

endmodule

// File: tb/tb_mmio_bridge_ng.sv
// -----------------------------------------------------------------------------
// tb_mmio_bridge_ng
//   Directed bench for mmio_bridge_ng in its default 8-channel configuration.
//   Inputs are driven and outputs sampled on the falling clock edge. The
//   accept edge of each access is the rising edge right after the request is
//   raised; "Nk" below is the k-th falling edge after that request was driven.
// -----------------------------------------------------------------------------
module tb_mmio_bridge_ng;

  localparam int unsigned N = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req;
  logic            we;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            ready;
  logic            ack;
  logic [31:0]     rdata;
  logic            err;
  logic [15:0]     err_count;
  logic [N-1:0]    peri_req;
  logic            peri_we;
  logic [31:0]     peri_addr;
  logic [31:0]     peri_wdata;
  logic [N*32-1:0] peri_rdata;
  logic [N-1:0]    peri_ack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_bridge_ng dut (
    .clk_from_cpu   (clk),
    .rst_from_cpu   (rst),
    .req_from_cpu   (req),
    .we_from_cpu    (we),
    .addr_from_cpu  (addr),
    .wdata_from_cpu (wdata),
    .ready_to_cpu   (ready),
    .ack_to_cpu     (ack),
    .rdata_to_cpu   (rdata),
    .err_to_cpu     (err),
    .err_count      (err_count),
    .peri_req       (peri_req),
    .peri_we        (peri_we),
    .peri_addr      (peri_addr),
    .peri_wdata     (peri_wdata),
    .peri_rdata     (peri_rdata),
    .peri_ack       (peri_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    req        = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    peri_ack   = '0;
    peri_rdata = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_ready",      32'(ready),      32'h1);
    check("rst_ack",        32'(ack),        32'h0);
    check("rst_err",        32'(err),        32'h0);
    check("rst_rdata",      rdata,           32'h0);
    check("rst_peri_req",   32'(peri_req),   32'h0);
    check("rst_peri_we",    32'(peri_we),    32'h0);
    check("rst_peri_addr",  peri_addr,       32'h0);
    check("rst_peri_wdata", peri_wdata,      32'h0);
    check("rst_err_count",  32'(err_count),  32'h0);
    rst = 1'b1;
    @(negedge clk);

    // ---- 1: read ch0, ack in first WAIT cycle -> ack_to_cpu at t+2 ----
    we = 1'b0; addr = 32'h0000_1000; req = 1'b1;
    @(negedge clk);  // N1: WAIT
    req = 1'b0;
    check("t1_ready_busy", 32'(ready),    32'h0);
    check("t1_peri_req",   32'(peri_req), 32'h01);
    check("t1_peri_addr",  peri_addr,     32'h0000_1000);
    check("t1_ack_early",  32'(ack),      32'h0);
    peri_ack = 8'h01; peri_rdata[31:0] = 32'h1234_5678;
    @(negedge clk);  // N2: RESP
    peri_ack = '0;
    check("t1_ack",        32'(ack),      32'h1);
    check("t1_rdata",      rdata,         32'h1234_5678);
    check("t1_err",        32'(err),      32'h0);
    check("t1_req_pulse",  32'(peri_req), 32'h0);
    @(negedge clk);  // N3: IDLE
    check("t1_ack_once",   32'(ack),      32'h0);
    check("t1_ready_back", 32'(ready),    32'h1);

    // ---- 2: write LED (ch1), ack after 3 WAIT cycles -> ack_to_cpu at t+5 ----
    we = 1'b1; addr = 32'hFFFF_F060; wdata = 32'h0000_00A5; req = 1'b1;
    @(negedge clk);  // N1
    req = 1'b0;
    check("t2_peri_req",   32'(peri_req), 32'h02);
    check("t2_peri_we",    32'(peri_we),  32'h1);
    check("t2_peri_wdata", peri_wdata,    32'h0000_00A5);
    @(negedge clk);  // N2
    check("t2_req_pulse",  32'(peri_req), 32'h0);
    @(negedge clk);  // N3
    check("t2_ack_n3",     32'(ack),      32'h0);
    @(negedge clk);  // N4: fourth WAIT cycle, peripheral acks
    check("t2_ack_n4",     32'(ack),      32'h0);
    peri_ack = 8'h02; peri_rdata[63:32] = 32'hFFFF_FFFF;
    @(negedge clk);  // N5: RESP
    peri_ack = '0;
    check("t2_ack",        32'(ack),      32'h1);
    check("t2_rdata_wr",   rdata,         32'h0);
    check("t2_err",        32'(err),      32'h0);
    @(negedge clk);

    // ---- 3: decode miss -> ack_to_cpu at t+1 with error ----
    we = 1'b0; addr = 32'hFFFF_F0F0; req = 1'b1;
    @(negedge clk);  // N1: RESP
    req = 1'b0;
    check("t3_ack",        32'(ack),       32'h1);
    check("t3_err",        32'(err),       32'h1);
    check("t3_rdata",      rdata,          32'hDEAD_FFFF);
    check("t3_peri_req",   32'(peri_req),  32'h0);
    check("t3_err_count",  32'(err_count), 32'h1);
    @(negedge clk);
    check("t3_ready_back", 32'(ready),     32'h1);

    // ---- 4a: read SW (ch2), never acked -> timeout after 16 WAIT cycles ----
    we = 1'b0; addr = 32'hFFFF_F070; req = 1'b1;
    @(negedge clk);  // N1
    req = 1'b0;
    check("t4a_peri_req",  32'(peri_req),  32'h04);
    repeat (15) @(negedge clk);  // N16: last WAIT cycle
    check("t4a_ack_n16",   32'(ack),       32'h0);
    @(negedge clk);  // N17: RESP
    check("t4a_ack",       32'(ack),       32'h1);
    check("t4a_err",       32'(err),       32'h1);
    check("t4a_rdata",     rdata,          32'hDEAD_FFFF);
    check("t4a_err_count", 32'(err_count), 32'h2);
    @(negedge clk);

    // ---- 4b: same access, ack on the expiry cycle -> ack wins ----
    req = 1'b1;
    @(negedge clk);  // N1
    req = 1'b0;
    repeat (15) @(negedge clk);  // N16
    peri_ack = 8'h04; peri_rdata[95:64] = 32'hCAFE_0002;
    @(negedge clk);  // N17
    peri_ack = '0;
    check("t4b_ack",       32'(ack),       32'h1);
    check("t4b_err",       32'(err),       32'h0);
    check("t4b_rdata",     rdata,          32'hCAFE_0002);
    check("t4b_err_count", 32'(err_count), 32'h2);
    @(negedge clk);

    // ---- 5: request held during WAIT, stray ack on ch3 while ch2 selected ----
    we = 1'b0; addr = 32'hFFFF_F070; req = 1'b1;
    @(negedge clk);  // N1: WAIT on ch2; CPU switches to a ch3 request
    addr = 32'hFFFF_F078;
    peri_ack = 8'h08; peri_rdata[127:96] = 32'h3333_0003;
    check("t5_ready_busy", 32'(ready),     32'h0);
    @(negedge clk);  // N2
    check("t5_stray_ign",  32'(ack),       32'h0);
    check("t5_no_accept",  32'(peri_req),  32'h0);
    peri_ack = 8'h04; peri_rdata[95:64] = 32'h2222_0002;
    @(negedge clk);  // N3: RESP for ch2
    peri_ack = '0;
    check("t5_ack1",       32'(ack),       32'h1);
    check("t5_rdata1",     rdata,          32'h2222_0002);
    check("t5_err1",       32'(err),       32'h0);
    @(negedge clk);  // N4: IDLE, held request accepted at the next edge
    check("t5_ready_idle", 32'(ready),     32'h1);
    check("t5_req_idle",   32'(peri_req),  32'h0);
    @(negedge clk);  // N5: WAIT on ch3
    req = 1'b0;
    check("t5_peri_req2",  32'(peri_req),  32'h08);
    check("t5_peri_addr2", peri_addr,      32'hFFFF_F078);
    peri_ack = 8'h08;
    @(negedge clk);  // N6: RESP for ch3
    peri_ack = '0;
    check("t5_ack2",       32'(ack),       32'h1);
    check("t5_rdata2",     rdata,          32'h3333_0003);
    @(negedge clk);

    // ---- 6: reset during WAIT abandons the access ----
    we = 1'b1; addr = 32'hFFFF_F070; wdata = 32'h0000_0055; req = 1'b1;
    @(negedge clk);  // N1: WAIT
    req = 1'b0;
    check("t6_peri_wdata_pre", peri_wdata, 32'h0000_0055);
    rst = 1'b0;
    @(negedge clk);  // N2: reset taken at the previous edge
    rst = 1'b1;
    check("t6_ready",      32'(ready),      32'h1);
    check("t6_ack",        32'(ack),        32'h0);
    check("t6_err",        32'(err),        32'h0);
    check("t6_rdata",      rdata,           32'h0);
    check("t6_peri_req",   32'(peri_req),   32'h0);
    check("t6_peri_we",    32'(peri_we),    32'h0);
    check("t6_peri_addr",  peri_addr,       32'h0);
    check("t6_peri_wdata", peri_wdata,      32'h0);
    check("t6_err_count",  32'(err_count),  32'h0);
    @(negedge clk);
    check("t6_no_late_ack", 32'(ack),       32'h0);

    // Error counting restarts from zero after reset.
    we = 1'b0; addr = 32'hFFFF_F0F0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("t6_miss_ack",   32'(ack),        32'h1);
    check("t6_err_count1", 32'(err_count),  32'h1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
